// File: rtl/order_bram_rmw_ctrl.sv
// Read-modify-write sequencer for the single-port order-book BRAM.
// Serializes READ / WRITE / saturating ADD / CLEAR commands into BRAM cycles and returns one response each.
module order_bram_rmw_ctrl #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_sat,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, WRITE, RESP} state_t;
   typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ADD, OP_CLEAR} op_t;

   state_t                state;
   op_t                   op_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;

   logic signed [DATA_WIDTH+1:0] sum;
   logic                         sat_low;
   logic                         sat_high;
   logic [DATA_WIDTH-1:0]        add_val;

   // Two guard bits: the top bit flags a negative sum, the next one an overflow past the word.
   always_comb begin
      sum      = $signed({2'b00, mem_rdata}) + $signed({{2{data_q[DATA_WIDTH-1]}}, data_q});
      sat_low  = sum[DATA_WIDTH+1];
      sat_high = !sum[DATA_WIDTH+1] && sum[DATA_WIDTH];
      add_val  = sum[DATA_WIDTH-1:0];
      if (sat_low)
         add_val = '0;
      else if (sat_high)
         add_val = '1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_READ;
         addr_q    <= '0;
         data_q    <= '0;
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_sat   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  op_q      <= op_t'(cmd_op);
                  addr_q    <= cmd_addr;
                  data_q    <= cmd_data;
                  cmd_ready <= 1'b0;
                  mem_addr  <= cmd_addr;
                  if (op_t'(cmd_op) == OP_WRITE) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= cmd_data;
                     rsp_data  <= cmd_data;
                     rsp_sat   <= 1'b0;
                     state     <= WRITE;
                  end else begin
                     state <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               mem_addr <= addr_q;
               state    <= CAPTURE;
            end
            CAPTURE: begin
               case (op_q)
                  OP_ADD: begin
                     mem_wdata <= add_val;
                     rsp_data  <= add_val;
                     rsp_sat   <= sat_low | sat_high;
                     mem_we    <= 1'b1;
                     state     <= WRITE;
                  end
                  OP_CLEAR: begin
                     mem_wdata <= '0;
                     rsp_data  <= mem_rdata;
                     rsp_sat   <= 1'b0;
                     mem_we    <= 1'b1;
                     state     <= WRITE;
                  end
                  default: begin
                     rsp_data  <= mem_rdata;
                     rsp_sat   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               endcase
            end
            WRITE: begin
               mem_we    <= 1'b0;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_order_bram_rmw_ctrl.sv
// Scoreboard bench for order_bram_rmw_ctrl: a BRAM model on the memory port, a behavioural
// reference memory predicting every response, and a monitor checking data, saturation, latency and write pulses.
module tb_order_bram_rmw_ctrl;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_data = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_data;
   logic          rsp_sat;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   order_bram_rmw_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_sat(rsp_sat),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port BRAM: registered read, write-first
   logic [DW-1:0] bram [1024];
   always @(posedge clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : bram[mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [DW-1:0] data;
      logic          sat;
      int            lat;
      int            we;
      logic [AW-1:0] addr;
      int            acc;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] ref_mem [1024];
   int            checks = 0;
   int            errors = 0;
   int            bp_mode = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Response backpressure: 0 always ready, 1 random, 2 stalled
   initial begin
      forever begin
         @(negedge clk);
         if (bp_mode == 0)      rsp_ready = 1'b1;
         else if (bp_mode == 1) rsp_ready = ($urandom_range(0, 3) != 0);
         else                   rsp_ready = 1'b0;
      end
   end

   task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input bit track = 1'b1);
      int   n;
      exp_t e;
      longint s;
      logic [DW-1:0] old;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         chk("cmd_ready_timeout", {31'b0, cmd_ready}, 1);
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = data;
      if (track) begin
         old    = ref_mem[addr];
         e.addr = addr;
         e.acc  = cyc;
         e.sat  = 1'b0;
         case (op)
            2'd0: begin e.data = old; e.lat = 3; e.we = 0; end
            2'd1: begin e.data = data; e.lat = 2; e.we = 1; ref_mem[addr] = data; end
            2'd2: begin
               s = longint'(old) + longint'($signed(data));
               if (s < 0) begin
                  e.data = '0; e.sat = 1'b1;
               end else if (s > 64'sh0000_0000_FFFF_FFFF) begin
                  e.data = '1; e.sat = 1'b1;
               end else begin
                  e.data = s[DW-1:0];
               end
               e.lat = 4; e.we = 1; ref_mem[addr] = e.data;
            end
            default: begin e.data = old; e.lat = 4; e.we = 1; ref_mem[addr] = '0; end
         endcase
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_data  = $urandom;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue_empty", q.size(), 0);
   endtask

   // Monitor
   logic [DW-1:0] held_data;
   logic          prev_valid = 1'b0;
   bit            ready_chk = 1'b0;
   int            we_cnt = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) begin
            prev_valid = 1'b0;
            ready_chk  = 1'b0;
            continue;
         end
         if (mem_we) begin
            we_cnt++;
            if (q.size() != 0) chk("write_addr", mem_addr, q[0].addr);
         end
         if (ready_chk) begin
            ready_chk = 1'b0;
            chk("ready_after_rsp", {31'b0, cmd_ready}, 1);
         end
         if (rsp_valid && !prev_valid) begin
            held_data = rsp_data;
            if (q.size() == 0) chk("unexpected_rsp", 1, 0);
            else               chk("latency", cyc - q[0].acc, q[0].lat);
         end
         if (rsp_valid && !rsp_ready) begin
            chk("hold_data", rsp_data, held_data);
            chk("hold_no_we", {31'b0, mem_we}, 0);
            chk("hold_no_ready", {31'b0, cmd_ready}, 0);
         end
         if (rsp_valid && rsp_ready && q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_sat", {31'b0, rsp_sat}, {31'b0, e.sat});
            chk("we_pulses", we_cnt, e.we);
            we_cnt    = 0;
            ready_chk = 1'b1;
         end
         prev_valid = rsp_valid;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int n;
      for (int i = 0; i < 1024; i++) begin
         bram[i]    = '0;
         ref_mem[i] = '0;
      end
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_sat", {31'b0, rsp_sat}, 0);
      chk("rst_mem_addr", {22'b0, mem_addr}, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 1);

      // Directed cases
      do_cmd(2'd1, 10'h005, 32'h0000_00C8);
      do_cmd(2'd0, 10'h005, 32'h0);
      do_cmd(2'd1, 10'h010, 32'h0000_0064);
      do_cmd(2'd2, 10'h010, 32'hFFFF_FFCE);
      do_cmd(2'd0, 10'h010, 32'h0);
      do_cmd(2'd2, 10'h010, 32'hFFFF_FF9C);
      do_cmd(2'd1, 10'h011, 32'hFFFF_FFF0);
      do_cmd(2'd2, 10'h011, 32'h0000_0020);
      do_cmd(2'd1, 10'h3FF, 32'h0000_1234);
      do_cmd(2'd3, 10'h3FF, 32'hDEAD_BEEF);
      do_cmd(2'd0, 10'h3FF, 32'h0);
      drain();

      // Backpressure on an ADD response
      bp_mode = 2;
      do_cmd(2'd2, 10'h011, 32'h0000_0001);
      n = 0;
      while (!rsp_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("bp_rsp_seen", {31'b0, rsp_valid}, 1);
      repeat (10) @(negedge clk);
      bp_mode = 0;
      do_cmd(2'd0, 10'h011, 32'h0);
      drain();

      // Reset during CAPTURE of an ADD
      do_cmd(2'd1, 10'h020, 32'd7);
      drain();
      do_cmd(2'd2, 10'h020, 32'd5, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("midrst_no_we", {31'b0, mem_we}, 0);
         chk("midrst_no_rsp", {31'b0, rsp_valid}, 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("midrst_cmd_ready", {31'b0, cmd_ready}, 1);
      chk("midrst_no_we_after", {31'b0, mem_we}, 0);
      do_cmd(2'd0, 10'h020, 32'h0);
      drain();

      // Randomized traffic with random backpressure
      bp_mode = 1;
      for (int i = 0; i < 80; i++) begin
         a = ($urandom_range(0, 8) == 8) ? 10'h3FF : AW'($urandom_range(0, 7));
         case ($urandom_range(0, 4))
            0:       d = 32'hFFFF_FFFF;
            1:       d = 32'h8000_0000 + 32'($urandom_range(0, 3));
            2:       d = 32'($urandom_range(0, 255)) - 32'd128;
            default: d = $urandom;
         endcase
         do_cmd(2'($urandom_range(0, 3)), a, d);
      end
      bp_mode = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/order_bram_rmw_ctrl.md
Name: order_bram_rmw_ctrl

Overview:
- Master-side controller for the single-port order-book BRAM (one-cycle registered read, write-first address port).
- Accepts one command at a time from order-processing logic over a valid/ready interface.
- Sequences the BRAM read, modify and write-back cycles and returns a result over a valid/ready response channel.
- Supported operations: READ, WRITE, signed quantity ADD with saturation, and CLEAR with old-value return.

Parameters:
- ADDR_WIDTH, 10 (`ADDR_WIDTH): BRAM address width.
- DATA_WIDTH, 32 (`DATA_WIDTH): BRAM word width; stored values are unsigned.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 READ, 01 WRITE, 10 ADD, 11 CLEAR.
- cmd_addr  in  ADDR_WIDTH  target word.
- cmd_data  in  DATA_WIDTH  WRITE value, or ADD delta (two's complement); ignored for READ and CLEAR.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_WIDTH  result word (see Behaviour).
- rsp_sat  out  1  ADD result was saturated.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  ADDR_WIDTH  BRAM address.
- mem_wdata  out  DATA_WIDTH  BRAM write data.
- mem_rdata  in  DATA_WIDTH  BRAM read data; valid the cycle after the address is presented.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE; cmd_ready=1 once rst_n deasserts; rsp_valid=0, rsp_data=0, rsp_sat=0, mem_we=0, mem_addr=0, mem_wdata=0; latched op/addr/data registers=0.
- FSM states: IDLE, ISSUE, CAPTURE, WRITE, RESP.
- cmd_ready=1 only in IDLE. The command is latched on the edge where cmd_valid&&cmd_ready.
- Transitions out of IDLE on accept: READ/ADD/CLEAR -> ISSUE; WRITE -> WRITE.
- ISSUE: mem_addr=latched addr, mem_we=0 -> CAPTURE.
- CAPTURE: mem_rdata is valid in this state and is registered as old.
  - READ: result=old -> RESP.
  - CLEAR: new=0, result=old -> WRITE.
  - ADD: new=sat(old+delta), result=new -> WRITE.
- WRITE: mem_we=1, mem_addr=latched addr, mem_wdata=new (WRITE op: new=cmd_data, result=cmd_data) -> RESP.
- RESP: rsp_valid=1. rsp_data, rsp_sat and mem_addr are held stable; mem_we=0. On rsp_valid&&rsp_ready -> IDLE (cmd_ready=1 next cycle; no same-cycle accept).
- mem_we is 1 only in WRITE state, for exactly one cycle per WRITE/ADD/CLEAR command.
- Latency from accept edge to rsp_valid rising: WRITE 2 cycles, READ 3, ADD/CLEAR 4. Throughput is one command per (latency+1) cycles when rsp_ready=1.
- ADD arithmetic:
  - Compute in DATA_WIDTH+2 signed bits: zero-extend old, sign-extend delta.
  - Sum<0 -> 0 with rsp_sat=1.
  - Sum>2^DATA_WIDTH-1 -> 2^DATA_WIDTH-1 with rsp_sat=1.
  - Otherwise exact, rsp_sat=0.
- rsp_sat=0 for all non-ADD ops.
- Back-to-back same address: no hazard, since commands are strictly serialized and each write completes before its response.
- Backpressure: rsp_ready low holds RESP indefinitely; cmd_ready stays 0; no BRAM writes occur.
- Reset mid-operation: all outputs return to reset values immediately. A pending write is abandoned; mem_we deasserts asynchronously, so no partial write. BRAM contents are not cleared by reset.
- cmd_op/cmd_data/cmd_addr changes after acceptance have no effect.

Test Plan:
- WRITE addr 0x005 data 0x0000_00C8, then READ 0x005 -> mem_we pulse 1 cycle at addr 0x005; READ rsp_data=0x0000_00C8, rsp_valid 3 cycles after accept, rsp_sat=0.
- Stored 0x64 at 0x010, ADD delta 0xFFFF_FFCE (-50) -> rsp_data=0x32, rsp_sat=0; subsequent READ returns 0x32.
- Stored 0x32, ADD delta -100 -> rsp_data=0, rsp_sat=1. Stored 0xFFFF_FFF0, ADD +0x20 -> rsp_data=0xFFFF_FFFF, rsp_sat=1.
- CLEAR addr 0x3FF holding 0x1234 -> rsp_data=0x1234, response 4 cycles after accept; READ 0x3FF -> 0.
- Hold rsp_ready=0 for 10 cycles after ADD -> rsp_valid/rsp_data stable, cmd_ready=0, mem_we=0 throughout; release -> IDLE, next command accepted one cycle later.
- Assert rst_n=0 during CAPTURE of an ADD to 0x020 (value 7) -> mem_we never asserts, rsp_valid=0, cmd_ready=1 after release; READ 0x020 -> 7.
